fun_arbiter: RTL and testbench

//   Shares one fun unit (result = a * floor(cbrt(b)); 8b operands, 11b result, start/busy) among N requesters.

---
 rtl/fun_pkg.sv | 13 +
 rtl/rr_pick.sv | 25 ++
 rtl/fun_arbiter.sv | 145 ++++++++++++++
 tb/tb_fun_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fun_pkg.sv
// rtl/fun_pkg.sv - shared widths and arbiter FSM states for the fun unit wrapper
package fun_pkg;
  localparam int FUN_OP_W  = 8;
  localparam int FUN_RES_W = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searches upward from ptr_i+1 with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    logic found;
    int   cand;
    found = 1'b0;
    idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IW'(cand);
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/fun_arbiter.sv
// rtl/fun_arbiter.sv - round-robin sharing of one fun unit among N_REQ requesters
// Optional WAIT-state timeout enabled by defining FUN_ARB_TIMEOUT_EN.
module fun_arbiter
  import fun_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [FUN_OP_W*N_REQ-1:0] req_a,
  input  logic [FUN_OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [FUN_RES_W-1:0]      rsp_result,
  output logic                      rsp_err,
  output logic [FUN_OP_W-1:0]       fun_a,
  output logic [FUN_OP_W-1:0]       fun_b,
  output logic                      fun_start,
  input  logic                      fun_busy,
  input  logic [FUN_RES_W-1:0]      fun_result
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 1 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("fun_arbiter: parameter out of range");
  end

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, rr_ptr_q, rr_ptr_d;
  logic [FUN_OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [FUN_RES_W-1:0] res_q, res_d;
  logic                 err_q, err_d;
  logic [N_REQ-1:0]     ready_q, ready_d, rsp_q, rsp_d;
  logic                 start_q, start_d;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef FUN_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timed_out;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + 16'd1;
    timed_out = (state_q == WAIT) && (cnt_d == 16'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic timed_out;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !fun_busy) begin
          idx_d    = pick_idx;
          rr_ptr_d = pick_idx;
          a_d      = req_a[int'(pick_idx)*FUN_OP_W +: FUN_OP_W];
          b_d      = req_b[int'(pick_idx)*FUN_OP_W +: FUN_OP_W];
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      // busy only rises the cycle after start, so it is not trusted here
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!fun_busy) begin
          res_d   = fun_result;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timed_out) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pulse outputs are registered copies of the state being entered.
    start_d = (state_d == ISSUE);
    for (int i = 0; i < N_REQ; i++) begin
      ready_d[i] = (state_d == ISSUE) && (idx_d == IW'(i));
      rsp_d[i]   = (state_d == DONE)  && (idx_d == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= '0;
      rsp_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rsp_q    <= rsp_d;
      start_q  <= start_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign fun_a      = a_q;
  assign fun_b      = b_q;
  assign fun_start  = start_q;
endmodule

// File: tb/tb_fun_arbiter.sv
// tb/tb_fun_arbiter.sv - directed bench for fun_arbiter with a behavioural fun unit
// Timeout scenario runs only when FUN_ARB_TIMEOUT_EN is defined.
module tb_fun_arbiter;
  localparam int N = 4;
`ifdef FUN_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 2000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [10:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  fun_a, fun_b;
  logic        fun_start;
  logic        fun_busy;
  logic [10:0] fun_result;
  logic        busy_force = 1'b0;
  int          busy_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fun_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .fun_a      (fun_a),
    .fun_b      (fun_b),
    .fun_start  (fun_start),
    .fun_busy   (fun_busy),
    .fun_result (fun_result)
  );

  function automatic int icbrt(input int b);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  // fun unit model: busy for 4 cycles starting the cycle after start
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt   <= 0;
      fun_result <= '0;
    end else if (fun_start) begin
      busy_cnt   <= 4;
      fun_result <= 11'(int'(fun_a) * icbrt(int'(fun_b)));
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign fun_busy = busy_force | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready == 4'b0 && cyc < 60);
    check({tag, "_ready"}, 32'(req_ready), 32'(oh(idx)));
    check({tag, "_start"}, 32'(fun_start), 32'd1);
    check({tag, "_fun_ab"}, {16'd0, fun_a, fun_b}, {16'd0, a, b});
  endtask

  task automatic wait_rsp(input string tag, input int idx, input logic [10:0] res, input logic err);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rsp_valid == 4'b0 && cyc < 100);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh(idx)));
    check({tag, "_result"}, 32'(rsp_result), 32'(res));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int seen;
    logic [7:0] ta [5];
    logic [7:0] tb_ [5];
    logic [10:0] tr [5];
    int ord [5];

    // reset state
    repeat (3) @(negedge clk);
    check("reset_pulses", {20'd0, req_ready, rsp_valid, 3'd0, fun_start}, 32'd0);
    check("reset_rsp", {20'd0, rsp_err, rsp_result}, 32'd0);
    check("reset_fun_ab", {16'd0, fun_a, fun_b}, 32'd0);
    rst = 1'b1;

    // 1: single request
    set_req(0, 8'd5, 8'd27);
    wait_ready("t1", 0, 8'd5, 8'd27);
    req_valid = '0;
    @(negedge clk);
    check("t1_start_pulse", {28'd0, req_ready}, {31'd0, fun_start});
    check("t1_start_low", 32'(fun_start), 32'd0);
    wait_rsp("t1", 0, 11'd15, 1'b0);
    @(negedge clk);
    check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("t1_result_hold", 32'(rsp_result), 32'd15);

    // 2: two requesters raised together
    do_reset();
    set_req(0, 8'd3, 8'd64);
    set_req(2, 8'd9, 8'd125);
    wait_ready("t2a", 0, 8'd3, 8'd64);
    req_valid[0] = 1'b0;
    wait_rsp("t2a", 0, 11'd12, 1'b0);
    wait_ready("t2b", 2, 8'd9, 8'd125);
    req_valid[2] = 1'b0;
    wait_rsp("t2b", 2, 11'd45, 1'b0);

    // 3: all four held, rotation 0,1,2,3,0
    do_reset();
    ta  = '{8'd255, 8'd97, 8'd10, 8'd7, 8'd255};
    tb_ = '{8'd200, 8'd0,  8'd8,  8'd100, 8'd200};
    tr  = '{11'd1275, 11'd0, 11'd20, 11'd28, 11'd1275};
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_req(i, ta[i], tb_[i]);
    for (int k = 0; k < 5; k++) begin
      wait_ready($sformatf("t3_%0d", k), ord[k], ta[k], tb_[k]);
      wait_rsp($sformatf("t3_%0d", k), ord[k], tr[k], 1'b0);
    end
    req_valid = '0;

    // 4: busy held in IDLE blocks the grant
    busy_force = 1'b1;
    set_req(1, 8'd2, 8'd8);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != 4'b0) seen++;
    end
    check("t4_no_grant_busy", 32'(seen), 32'd0);
    busy_force = 1'b0;
    wait_ready("t4", 1, 8'd2, 8'd8);
    req_valid = '0;
    wait_rsp("t4", 1, 11'd4, 1'b0);

    // 5: async reset during WAIT
    set_req(3, 8'd1, 8'd1);
    wait_ready("t5a", 3, 8'd1, 8'd1);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rst_pulses", {20'd0, req_ready, rsp_valid, 3'd0, fun_start}, 32'd0);
    check("t5_rst_rsp", {20'd0, rsp_err, rsp_result}, 32'd0);
    check("t5_rst_fun_ab", {16'd0, fun_a, fun_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) seen++;
    end
    check("t5_no_rsp_after_abort", 32'(seen), 32'd0);
    set_req(3, 8'd44, 8'd255);
    wait_ready("t5b", 3, 8'd44, 8'd255);
    req_valid = '0;
    wait_rsp("t5b", 3, 11'd264, 1'b0);

`ifdef FUN_ARB_TIMEOUT_EN
    // 6: fun busy stuck -> timeout response
    set_req(0, 8'd1, 8'd1);
    wait_ready("t6", 0, 8'd1, 8'd1);
    req_valid = '0;
    busy_force = 1'b1;
    wait_rsp("t6_timeout", 0, 11'd0, 1'b1);
    busy_force = 1'b0;
    set_req(1, 8'd2, 8'd8);
    wait_ready("t6_after", 1, 8'd2, 8'd8);
    req_valid = '0;
    wait_rsp("t6_after", 1, 11'd4, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
